cond_accum: RTL and testbench
=============================

# cond_accum

Multi-channel conditional accumulator: a parametrised, clocked successor of the combinational conditional-reassignment chain. Each accepted op updates one channel's register with load, add, or compare-select, i.e. `acc = (acc == cmp) ? acc : data`. The result is returned through a registered valid/ready output stage. A clear-all op sweeps every channel under a small FSM. It sits between a command source and a result consumer inside generated datapaths.

## Interface
Parameters:
- WIDTH, 4, accumulator/data width (≥1)
- NUM_CH, 3, number of channels (≥1)
- CH_W, max(1, $clog2(NUM_CH)), channel index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  op present
- in_ready  out  1  op accepted when in_valid && in_ready at posedge clk
- in_op  in  2  0 LOAD, 1 ADD, 2 SEL, 3 CLEAR_ALL
- in_ch  in  CH_W  target channel (ignored for CLEAR_ALL)
- in_data  in  WIDTH  operand
- in_cmp  in  WIDTH  compare value for SEL
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_ch  out  CH_W  channel of result
- out_data  out  WIDTH  channel value after update
- out_err  out  1  in_ch ≥ NUM_CH
- out_ovf  out  1  ADD carried out of WIDTH bits

## Operation
- Reset: all acc = 0; out_valid, out_ch, out_data, out_err, out_ovf = 0; FSM = IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational, and it is 1 immediately after reset.
- LOAD: acc[ch] = in_data.
- ADD: acc[ch] = (acc[ch] + in_data) mod 2^WIDTH; out_ovf = carry.
- SEL: acc[ch] = (acc[ch] == in_cmp) ? acc[ch] : in_data.
- Invalid channel (in_ch ≥ NUM_CH, LOAD/ADD/SEL): no acc changes; result has out_err = 1, out_data = 0.
- FSM: IDLE → CLEAR on accepted CLEAR_ALL.
  - CLEAR zeroes acc[i] for i = 0..NUM_CH-1, one per cycle.
  - After the last channel: → IDLE and emit one result with out_ch = NUM_CH-1, out_data = 0, out_err = 0, out_ovf = 0.
- Output register holds its value while out_valid && !out_ready.

## Timing
- LOAD/ADD/SEL accepted at edge N:
  - acc written at edge N.
  - out_valid = 1 after edge N, carrying the new value (1-cycle latency).
- Back-to-back ops on the same channel: the second sees the first's updated value. No hazard stall.
- Throughput: one op per cycle when out_ready = 1 continuously.
- CLEAR_ALL accepted at edge N:
  - acc[i] is cleared at edge N+1+i.
  - out_valid asserts after edge N+NUM_CH.
  - in_ready = 0 from edge N until the FSM returns to IDLE.
  - CLEAR does not wait on out_ready; a pending prior result is kept until consumed.
  - Final emission waits in CLEAR on the last channel until the output slot is free.
- Simultaneous out_ready and in_valid with a full output slot: the old result is consumed and the new one is loaded in the same edge.
- Reset asserted mid-CLEAR or with a result pending: all state returns to reset values immediately; the pending result is lost.

## Configuration
- COND_ACCUM_SAT_EN defined: ADD saturates to 2^WIDTH−1 on carry; out_ovf = 1.
- COND_ACCUM_SAT_EN undefined: ADD wraps; out_ovf still reports carry.
- All other behaviour is identical in both builds.

## Structure
- Package cond_accum_pkg holds:
  - op enum: OP_LOAD, OP_ADD, OP_SEL, OP_CLEAR_ALL
  - state enum: IDLE, CLEAR
- Sub-module cond_accum_alu (combinational) takes op, acc, data, cmp and returns next value and ovf. The saturation macro is applied only here.
- The top level holds the acc array, FSM, sweep counter and output register.

## Test plan
- Reset then LOAD ch0=2 → out_data=2, out_ch=0, one cycle after acceptance. Then ADD ch0 data=3 → 5.
- ch1: LOAD 2. SEL cmp=2 data=9 → 2 (kept). SEL cmp=4 data=9 → 9.
- ch2: LOAD 0xE, ADD 3 → wrap build: out_data=1, out_ovf=1; COND_ACCUM_SAT_EN build: out_data=0xF, out_ovf=1.
- in_ch=3 (NUM_CH=3), LOAD 7 → out_err=1, out_data=0; other channels unchanged on readback LOADs/ADD 0.
- Load all channels non-zero, issue CLEAR_ALL → in_ready low 3 cycles, one result out_ch=2 out_data=0; ADD 0 on each channel returns 0.
- Hold out_ready=0 with a result pending → in_ready=0, output stable. Assert rst mid-CLEAR → out_valid=0, in_ready=1, all channels read 0.

Source files
------------

// File: rtl/cond_accum_pkg.sv
// Shared types for the multi-channel conditional accumulator.
package cond_accum_pkg;

  typedef enum logic [1:0] {
    OP_LOAD      = 2'd0,
    OP_ADD       = 2'd1,
    OP_SEL       = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/cond_accum_alu.sv
// Per-op next-value datapath for one accumulator channel.
// COND_ACCUM_SAT_EN: ADD saturates to all-ones on carry instead of wrapping.
module cond_accum_alu
  import cond_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, data};
    nxt = acc;
    ovf = 1'b0;
    unique case (op)
      OP_LOAD: nxt = data;
      OP_ADD: begin
        ovf = sum[WIDTH];
`ifdef COND_ACCUM_SAT_EN
        nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        nxt = sum[WIDTH-1:0];
`endif
      end
      OP_SEL:       nxt = (acc == cmp) ? acc : data;
      OP_CLEAR_ALL: nxt = acc;
    endcase
  end

endmodule

// File: rtl/cond_accum.sv
// Multi-channel conditional accumulator with registered valid/ready result and a
// clear-all sweep FSM. Saturating ADD is selected by COND_ACCUM_SAT_EN (see alu).
module cond_accum
  import cond_accum_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_cmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q [NUM_CH];

  op_e              op;
  logic             slot_free, accept, is_clr_op, ch_ok, last;
  logic             clr_en, emit;
  logic [31:0]      ch_ext;
  logic [WIDTH-1:0] cur_acc, alu_nxt;
  logic             alu_ovf;

  assign op        = op_e'(in_op);
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_clr_op = (op == OP_CLEAR_ALL);
  assign ch_ext    = 32'(in_ch);
  assign ch_ok     = ch_ext < NUM_CH;
  assign last      = (cnt_q == CH_W'(NUM_CH - 1));

  always_comb begin
    cur_acc = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (in_ch == CH_W'(i)) cur_acc = acc_q[i];
    end
  end

  cond_accum_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op  (op),
    .acc (cur_acc),
    .data(in_data),
    .cmp (in_cmp),
    .nxt (alu_nxt),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept && is_clr_op) state_d = CLEAR;
      CLEAR: if (last && slot_free)   state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && slot_free;
    clr_en   = (state_q == CLEAR);
    // The sweep parks on the last channel until the output slot frees up.
    emit     = (state_q == CLEAR) && last && slot_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_q <= '0;
    else if (state_q == IDLE)   cnt_q <= '0;
    else if (!last)             cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (clr_en && cnt_q == CH_W'(i)) begin
          acc_q[i] <= '0;
        end else if (accept && !is_clr_op && ch_ok && in_ch == CH_W'(i)) begin
          acc_q[i] <= alu_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept && !is_clr_op) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_data  <= ch_ok ? alu_nxt : '0;
      out_err   <= !ch_ok;
      out_ovf   <= ch_ok && alu_ovf;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_ch    <= CH_W'(NUM_CH - 1);
      out_data  <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_accum.sv
// Self-checking bench for cond_accum: directed steps plus random traffic against an
// arithmetic reference model with an in-order result scoreboard.
module tb_cond_accum;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int CW = 2;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [1:0]    in_op;
  logic [CW-1:0] in_ch;
  logic [W-1:0]  in_data, in_cmp;
  logic          out_valid, out_ready;
  logic [CW-1:0] out_ch;
  logic [W-1:0]  out_data;
  logic          out_err, out_ovf;

  cond_accum #(
    .WIDTH (W),
    .NUM_CH(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .in_cmp   (in_cmp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_data (out_data),
    .out_err  (out_err),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
    logic          err;
    logic          ovf;
  } res_t;

  res_t q[$];
  int   macc[N];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) macc[i] = 0;
  endtask

  // Apply one accepted op to the reference model and queue its expected result.
  task automatic model_op(input int op, input int ch, input int d, input int c);
    res_t r;
    int   nv;
    bit   ov;
    ov = 1'b0;
    if (op == 3) begin
      for (int i = 0; i < N; i++) macc[i] = 0;
      r.ch = CW'(N - 1); r.data = '0; r.err = 1'b0; r.ovf = 1'b0;
    end else if (ch >= N) begin
      r.ch = CW'(ch); r.data = '0; r.err = 1'b1; r.ovf = 1'b0;
    end else begin
      nv = macc[ch];
      case (op)
        0: nv = d;
        1: begin
          nv = macc[ch] + d;
          ov = (nv > MAXV);
`ifdef COND_ACCUM_SAT_EN
          if (ov) nv = MAXV;
`else
          nv = nv % (MAXV + 1);
`endif
        end
        default: nv = (macc[ch] == c) ? macc[ch] : d;
      endcase
      macc[ch] = nv;
      r.ch = CW'(ch); r.data = W'(nv); r.err = 1'b0; r.ovf = ov;
    end
    q.push_back(r);
  endtask

  // One clock: sample handshakes before the edge, then score/update after it.
  task automatic tick();
    bit   a, o;
    res_t got, e;
    int   cop, cch, cd, cc;
    #1;
    a   = in_valid && in_ready;
    o   = out_valid && out_ready;
    got = '{ch: out_ch, data: out_data, err: out_err, ovf: out_ovf};
    cop = int'(in_op); cch = int'(in_ch); cd = int'(in_data); cc = int'(in_cmp);
    @(posedge clk);
    #1;
    if (o) begin
      if (q.size() == 0) begin
        chk("spurious_result", 32'(o), 32'(0));
      end else begin
        e = q.pop_front();
        chk("sb_ch",   32'(got.ch),   32'(e.ch));
        chk("sb_data", 32'(got.data), 32'(e.data));
        chk("sb_err",  32'(got.err),  32'(e.err));
        chk("sb_ovf",  32'(got.ovf),  32'(e.ovf));
      end
    end
    if (a) model_op(cop, cch, cd, cc);
    @(negedge clk);
  endtask

  task automatic send(input int op, input int ch, input int d, input int c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = 2'(op); in_ch = CW'(ch); in_data = W'(d); in_cmp = W'(c);
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'(0));
    tick();
    in_valid = 1'b0;
    if (op != 3) chk("latency_valid", 32'(out_valid), 32'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_ch = '0; in_data = '0; in_cmp = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
    chk("rst_out_data",  32'(out_data),  32'(0));
    chk("rst_out_flags", 32'({out_ch, out_err, out_ovf}), 32'(0));

    send(0, 0, 2, 0);
    chk("load_ch0", 32'(out_data), 32'(2));
    chk("load_ch0_ch", 32'(out_ch), 32'(0));
    send(1, 0, 3, 0);
    chk("add_ch0", 32'(out_data), 32'(5));

    send(0, 1, 2, 0);
    send(2, 1, 9, 2);
    chk("sel_keep", 32'(out_data), 32'(2));
    send(2, 1, 9, 4);
    chk("sel_take", 32'(out_data), 32'(9));

    send(0, 2, 14, 0);
    send(1, 2, 3, 0);
`ifdef COND_ACCUM_SAT_EN
    chk("add_sat", 32'(out_data), 32'(15));
`else
    chk("add_wrap", 32'(out_data), 32'(1));
`endif
    chk("add_ovf", 32'(out_ovf), 32'(1));

    send(0, 3, 7, 0);
    chk("bad_ch_err",  32'(out_err),  32'(1));
    chk("bad_ch_data", 32'(out_data), 32'(0));
    send(1, 0, 0, 0);
    chk("keep_ch0", 32'(out_data), 32'(5));
    send(1, 1, 0, 0);
    chk("keep_ch1", 32'(out_data), 32'(9));

    for (int i = 0; i < N; i++) send(0, i, i + 1, 0);
    send(3, 0, 0, 0);
    n = 0;
    while (!in_ready && n < 20) begin
      n++;
      tick();
    end
    chk("clear_busy_cycles", 32'(n), 32'(N));
    chk("clear_valid", 32'(out_valid), 32'(1));
    chk("clear_ch",    32'(out_ch),    32'(N - 1));
    chk("clear_data",  32'(out_data),  32'(0));
    for (int i = 0; i < N; i++) begin
      send(1, i, 0, 0);
      chk("after_clear", 32'(out_data), 32'(0));
    end

    send(0, 0, 6, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_ch = 2'd1; in_data = 4'd4; in_cmp = '0;
    #1;
    chk("hold_in_ready", 32'(in_ready), 32'(0));
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_data",  32'(out_data),  32'(held));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("swap_data", 32'(out_data), 32'(4));

    send(3, 0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("midclr_rst_valid", 32'(out_valid), 32'(0));
    chk("midclr_rst_ready", 32'(in_ready),  32'(1));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      send(1, i, 0, 0);
      chk("after_rst", 32'(out_data), 32'(0));
    end

    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      n         = int'($urandom_range(0, 15));
      in_op     = (n == 0) ? 2'd3 : 2'(n % 3);
      in_ch     = CW'($urandom_range(0, 3));
      in_data   = W'($urandom);
      in_cmp    = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
